jtcontra_colmix_n: RTL and testbench

- Parametrised N-layer colour mixer and palette lookup, successor to the fixed two-layer 007593-style mixer.
- Selects one layer pixel per dot by fixed priority with per-layer transparency and enable masks.
- Fetches a 2-byte colour entry from CPU-writable palette RAM with an explicit read sequencer, then applies blanking delay.
- Sits between the tile/sprite generators and the video output of each game core.

---
 rtl/jtcontra_colmix_pkg.sv | 26 ++
 rtl/jtcontra_colmix_prio.sv | 32 +++
 rtl/jtcontra_colmix_n.sv | 160 ++++++++++++++++
 tb/tb_jtcontra_colmix_n.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/jtcontra_colmix_pkg.sv
// Shared types and helpers for the N-layer colour mixer.
package jtcontra_colmix_pkg;

    // Palette fetch sequencer states
    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RD_HI = 2'd1,
        SEQ_RD_LO = 2'd2,
        SEQ_CAP   = 2'd3
    } seq_state_e;

    // Default pixel code width and the matching palette byte address width
    localparam int PXLW_DEF = 7;
    localparam int PAL_AW   = PXLW_DEF + 1;

    // Palette byte address width for a given pixel code width (two bytes per entry)
    function automatic int pal_aw(input int pxlw);
        return pxlw + (PAL_AW - PXLW_DEF);
    endfunction

    // Extract layer idx (w bits wide) from a packed pixel bus, zero-extended to 16 bits
    function automatic logic [15:0] layer_slice(input logic [63:0] pxl, input int idx, input int w);
        return 16'((pxl >> (idx * w)) & ((64'd1 << w) - 64'd1));
    endfunction

endpackage

// File: rtl/jtcontra_colmix_prio.sv
// Fixed-priority layer selector: layer 0 wins, transparent or masked layers are
// skipped, and the last layer is shown unmasked when nothing else qualifies.
module jtcontra_colmix_prio
    import jtcontra_colmix_pkg::*;
#(
    parameter int LAYERS = 2,
    parameter int PXLW   = 7,
    parameter int TRW    = 4
)(
    input  logic [LAYERS*PXLW-1:0] gfx_pxl,
    input  logic [LAYERS-1:0]      gfx_en,
    output logic [PXLW-1:0]        sel_code
);

    logic [63:0]     pxl_ext;
    logic [PXLW-1:0] code_i;

    assign pxl_ext = 64'(gfx_pxl);

    // Walk from lowest to highest priority so the lowest qualifying index wins
    always_comb begin
        code_i   = '0;
        sel_code = PXLW'(layer_slice(pxl_ext, LAYERS - 1, PXLW));
        for (int i = LAYERS - 1; i >= 0; i--) begin
            code_i = PXLW'(layer_slice(pxl_ext, i, PXLW));
            if (gfx_en[i] && (code_i[TRW-1:0] != '0)) begin
                sel_code = code_i;
            end
        end
    end

endmodule

// File: rtl/jtcontra_colmix_n.sv
// N-layer colour mixer: priority select, two-byte palette fetch through a
// small sequencer, then a blanking delay line that also masks RGB.
module jtcontra_colmix_n
    import jtcontra_colmix_pkg::*;
#(
    parameter int LAYERS    = 2,
    parameter int PXLW      = PXLW_DEF,
    parameter int TRW       = 4,
    parameter int CW        = 5,
    parameter int BLANK_DLY = 3
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    input  logic                   cpu_cen,
    input  logic                   pal_cs,
    input  logic                   cpu_rnw,
    input  logic [PXLW:0]          cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    input  logic [LAYERS*PXLW-1:0] gfx_pxl,
    input  logic [LAYERS-1:0]      gfx_en,
    output logic [CW-1:0]          red,
    output logic [CW-1:0]          green,
    output logic [CW-1:0]          blue,
    output logic                   seq_ovr
);

    localparam int AW = pal_aw(PXLW);
    localparam int EW = 3 * CW;      // palette entry width
    localparam int HW = EW - 8;      // bits taken from the even (high) byte

    logic [PXLW-1:0] sel_code;
    logic            pal_we;

    // palette RAM, one CPU port and one video read port
    logic [7:0]      mem [0:(1<<AW)-1];
    logic [AW-1:0]   vid_addr;
    logic [7:0]      vid_q;

    // sequencer
    seq_state_e      st, st_nx;
    logic [PXLW-1:0] code_l, code_nx;
    logic [HW-1:0]   hi_byte, hi_nx;
    logic [EW-1:0]   pend, pend_nx;
    logic            ovr_nx;

    // blanking delay line
    logic [EW-1:0]        rgb_dly [BLANK_DLY];
    logic [BLANK_DLY-1:0] hbl_dly;
    logic [BLANK_DLY-1:0] vbl_dly;
    logic [EW-1:0]        rgb_out;

    jtcontra_colmix_prio #(
        .LAYERS   (LAYERS),
        .PXLW     (PXLW),
        .TRW      (TRW)
    ) u_prio (
        .gfx_pxl  (gfx_pxl),
        .gfx_en   (gfx_en),
        .sel_code (sel_code)
    );

    assign pal_we   = cpu_cen & pal_cs & ~cpu_rnw;
    assign vid_addr = {code_l, st == SEQ_RD_LO};

    // RAM array: CPU writes, video reads see the pre-write contents
    always_ff @(posedge clk) begin
        if (pal_we) begin
            mem[cpu_addr] <= cpu_dout;
        end
        vid_q <= mem[vid_addr];
    end

    // CPU read-back register
    always_ff @(posedge clk) begin
        if (rst) begin
            pal_dout <= '0;
        end else begin
            pal_dout <= mem[cpu_addr];
        end
    end

    // Sequencer state and fetch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= SEQ_IDLE;
            code_l  <= '0;
            hi_byte <= '0;
            pend    <= '0;
            seq_ovr <= 1'b0;
        end else begin
            st      <= st_nx;
            code_l  <= code_nx;
            hi_byte <= hi_nx;
            pend    <= pend_nx;
            seq_ovr <= ovr_nx;
        end
    end

    // Next state: a pixel pulse always restarts the fetch, flagging any unfinished one
    always_comb begin
        st_nx   = st;
        code_nx = code_l;
        hi_nx   = hi_byte;
        pend_nx = pend;
        ovr_nx  = seq_ovr;
        if (pxl_cen) begin
            st_nx   = SEQ_RD_HI;
            code_nx = sel_code;
            if (st != SEQ_IDLE) begin
                ovr_nx = 1'b1;
            end
        end else begin
            case (st)
                SEQ_IDLE:  st_nx = SEQ_IDLE;
                SEQ_RD_HI: st_nx = SEQ_RD_LO;
                SEQ_RD_LO: begin
                    hi_nx = vid_q[HW-1:0];
                    st_nx = SEQ_CAP;
                end
                SEQ_CAP: begin
                    pend_nx = {hi_byte, vid_q};
                    st_nx   = SEQ_IDLE;
                end
                default:   st_nx = SEQ_IDLE;
            endcase
        end
    end

    // Blanking delay line, advanced once per pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < BLANK_DLY; k++) begin
                rgb_dly[k] <= '0;
            end
            hbl_dly <= '0;
            vbl_dly <= '0;
        end else if (pxl_cen) begin
            rgb_dly[0] <= pend;
            hbl_dly[0] <= LHBL;
            vbl_dly[0] <= LVBL;
            for (int k = 1; k < BLANK_DLY; k++) begin
                rgb_dly[k] <= rgb_dly[k-1];
                hbl_dly[k] <= hbl_dly[k-1];
                vbl_dly[k] <= vbl_dly[k-1];
            end
        end
    end

    assign LHBL_dly = hbl_dly[BLANK_DLY-1];
    assign LVBL_dly = vbl_dly[BLANK_DLY-1];
    assign rgb_out  = (LHBL_dly && LVBL_dly) ? rgb_dly[BLANK_DLY-1] : '0;
    assign {blue, green, red} = rgb_out;

endmodule

// File: tb/tb_jtcontra_colmix_n.sv
// Directed bench for the N-layer colour mixer: one 2-layer and one 4-layer
// instance share all control inputs.
module tb_jtcontra_colmix_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pxl_cen = 1'b0;
    logic        LHBL = 1'b1;
    logic        LVBL = 1'b1;
    logic        cpu_cen = 1'b0;
    logic        pal_cs = 1'b0;
    logic        cpu_rnw = 1'b1;
    logic [7:0]  cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic [13:0] gfx2 = '0;
    logic [1:0]  en2 = '0;
    logic [27:0] gfx4 = '0;
    logic [3:0]  en4 = '0;

    logic        hbl2, vbl2, ovr2, hbl4, vbl4, ovr4;
    logic [7:0]  pd2, pd4;
    logic [4:0]  r2, g2, b2, r4, g4, b4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtcontra_colmix_n #(.LAYERS(2)) dut2 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .LHBL_dly(hbl2), .LVBL_dly(vbl2), .cpu_cen(cpu_cen), .pal_cs(pal_cs),
        .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pd2),
        .gfx_pxl(gfx2), .gfx_en(en2), .red(r2), .green(g2), .blue(b2), .seq_ovr(ovr2)
    );

    jtcontra_colmix_n #(.LAYERS(4)) dut4 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .LHBL_dly(hbl4), .LVBL_dly(vbl4), .cpu_cen(cpu_cen), .pal_cs(pal_cs),
        .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pd4),
        .gfx_pxl(gfx4), .gfx_en(en4), .red(r4), .green(g4), .blue(b4), .seq_ovr(ovr4)
    );

    typedef struct {
        bit          four;
        logic [27:0] pxl;
        logic [3:0]  en;
        logic [14:0] exp;   // {red, green, blue}
    } vec_t;

    vec_t vecs [13];

    // colours as {red, green, blue}
    localparam logic [14:0] C05 = {5'h1F, 5'h00, 5'h1F};
    localparam logic [14:0] C12 = {5'h00, 5'h1F, 5'h00};
    localparam logic [14:0] C30 = {5'h00, 5'h00, 5'h1F};
    localparam logic [14:0] C20 = {5'h00, 5'h10, 5'h00};
    localparam logic [14:0] C43 = {5'h02, 5'h02, 5'h05};

    function automatic logic [27:0] pk(input logic [6:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // one pixel: a single-cycle pxl_cen then three idle cycles
    task automatic pix();
        @(negedge clk); pxl_cen = 1'b1;
        @(negedge clk); pxl_cen = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_cen = 1'b1; pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
        @(negedge clk);
        cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic set_gfx(input logic [27:0] p, input logic [3:0] e);
        gfx4 = p; en4 = e; gfx2 = p[13:0]; en2 = e[1:0];
    endtask

    initial begin
        logic [15:0] lh_in, lv_in;
        logic        exp_b;

        vecs[0]  = '{1'b0, pk(7'h05, 7'h12, 7'h00, 7'h00), 4'h3, C05};
        vecs[1]  = '{1'b0, pk(7'h10, 7'h12, 7'h00, 7'h00), 4'h3, C12};
        vecs[2]  = '{1'b0, pk(7'h05, 7'h12, 7'h00, 7'h00), 4'h2, C12};
        vecs[3]  = '{1'b0, pk(7'h05, 7'h12, 7'h00, 7'h00), 4'h1, C05};
        vecs[4]  = '{1'b0, pk(7'h10, 7'h20, 7'h00, 7'h00), 4'h3, C20};
        vecs[5]  = '{1'b0, pk(7'h05, 7'h12, 7'h00, 7'h00), 4'h0, C12};
        vecs[6]  = '{1'b1, pk(7'h10, 7'h20, 7'h40, 7'h30), 4'hF, C30};
        vecs[7]  = '{1'b1, pk(7'h10, 7'h20, 7'h43, 7'h30), 4'hF, C43};
        vecs[8]  = '{1'b1, pk(7'h05, 7'h20, 7'h43, 7'h30), 4'hF, C05};
        vecs[9]  = '{1'b1, pk(7'h05, 7'h12, 7'h43, 7'h30), 4'hE, C12};
        vecs[10] = '{1'b1, pk(7'h05, 7'h12, 7'h43, 7'h30), 4'h0, C30};
        vecs[11] = '{1'b1, pk(7'h10, 7'h12, 7'h43, 7'h30), 4'hB, C12};
        vecs[12] = '{1'b1, pk(7'h10, 7'h20, 7'h43, 7'h30), 4'hB, C30};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rgb2", {17'd0, r2, g2, b2}, 32'd0);
        chk("rst_rgb4", {17'd0, r4, g4, b4}, 32'd0);
        chk("rst_hbl", {31'd0, hbl2}, 32'd0);
        chk("rst_vbl", {31'd0, vbl2}, 32'd0);
        chk("rst_ovr", {31'd0, ovr2}, 32'd0);
        chk("rst_pdout", {24'd0, pd2}, 32'd0);
        rst = 1'b0;

        // zeroed palette, blanks followed three pixels late
        for (int a = 0; a < 256; a++) wr(8'(a), 8'h00);
        lh_in = 16'hFFE7;   // LHBL low for pixels 3 and 4
        for (int j = 0; j < 10; j++) begin
            LHBL = lh_in[j];
            pix();
            chk("zero_hbl", {31'd0, hbl2}, {31'd0, (j >= 2) ? lh_in[j-2] : 1'b0});
            chk("zero_vbl", {31'd0, vbl2}, {31'd0, (j >= 2)});
            chk("zero_rgb", {17'd0, r2, g2, b2}, 32'd0);
        end
        chk("zero_ovr", {31'd0, ovr2}, 32'd0);

        // palette contents
        wr(8'h0A, 8'h7C); wr(8'h0B, 8'h1F);
        wr(8'h24, 8'h03); wr(8'h25, 8'hE0);
        wr(8'h60, 8'h7C); wr(8'h61, 8'h00);
        wr(8'h20, 8'h01); wr(8'h21, 8'h23);
        wr(8'h40, 8'h02); wr(8'h41, 8'h00);
        wr(8'h80, 8'h00); wr(8'h81, 8'h05);
        wr(8'h86, 8'h14); wr(8'h87, 8'h42);

        @(negedge clk); cpu_addr = 8'h0A; pal_cs = 1'b1; cpu_rnw = 1'b1;
        @(negedge clk); chk("rd_0a", {24'd0, pd2}, 32'h7C);
        cpu_addr = 8'h25;
        @(negedge clk); chk("rd_25", {24'd0, pd4}, 32'hE0);
        pal_cs = 1'b0;

        // layer selection table
        for (int i = 0; i < 13; i++) begin
            set_gfx(vecs[i].pxl, vecs[i].en);
            repeat (6) pix();
            if (vecs[i].four) chk($sformatf("vec%0d_l4", i), {17'd0, r4, g4, b4}, {17'd0, vecs[i].exp});
            else              chk($sformatf("vec%0d_l2", i), {17'd0, r2, g2, b2}, {17'd0, vecs[i].exp});
        end

        // overrun: second pulse 2 clk after the first holds the old colour one extra pixel
        set_gfx(pk(7'h05, 7'h12, 7'h00, 7'h00), 4'h3);
        repeat (6) pix();
        chk("ovr_pre_rgb", {17'd0, r2, g2, b2}, {17'd0, C05});
        chk("ovr_pre_flag", {31'd0, ovr2}, 32'd0);
        set_gfx(pk(7'h10, 7'h12, 7'h00, 7'h00), 4'h3);
        @(negedge clk); pxl_cen = 1'b1;
        @(negedge clk); pxl_cen = 1'b0;
        @(negedge clk); pxl_cen = 1'b1;
        @(negedge clk); pxl_cen = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovr_flag", {31'd0, ovr2}, 32'd1);
        pix();
        pix();
        chk("ovr_hold", {17'd0, r2, g2, b2}, {17'd0, C05});
        pix();
        chk("ovr_new", {17'd0, r2, g2, b2}, {17'd0, C12});
        chk("ovr_sticky", {31'd0, ovr2}, 32'd1);

        // LVBL low for five pixels
        set_gfx(pk(7'h05, 7'h12, 7'h00, 7'h00), 4'h3);
        repeat (6) pix();
        lv_in = 16'hFF83;   // low for pixels 2..6
        for (int j = 0; j < 14; j++) begin
            LVBL = lv_in[j];
            pix();
            exp_b = (j >= 2) ? lv_in[j-2] : 1'b1;
            chk("vb_dly", {31'd0, vbl2}, {31'd0, exp_b});
            chk("vb_rgb", {17'd0, r2, g2, b2}, exp_b ? {17'd0, C05} : 32'd0);
        end
        LVBL = 1'b1;

        // reset in the middle of a fetch
        @(negedge clk); pxl_cen = 1'b1;
        @(negedge clk); pxl_cen = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mrst_rgb", {17'd0, r2, g2, b2}, 32'd0);
        chk("mrst_hbl", {31'd0, hbl2}, 32'd0);
        chk("mrst_vbl", {31'd0, vbl2}, 32'd0);
        chk("mrst_ovr", {31'd0, ovr2}, 32'd0);
        rst = 1'b0;
        repeat (6) pix();
        chk("mrst_after_ovr", {31'd0, ovr2}, 32'd0);
        chk("mrst_after_rgb", {17'd0, r2, g2, b2}, {17'd0, C05});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
